// File: rtl/alu_defs.sv
// Shared definitions for the ALU family (parallel and bit-serial variants).
// Holds the 4-bit control encoding, the 2-bit op-field values and the
// serial engine's state encoding.
package alu_defs;

    // Full control codes: {A_invert, B_invert/carry-in, op[1:0]}
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_NAND = 4'b1101;

    // Op field, ctrl[1:0]
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_bit_slice.sv
// One-bit ALU slice: optional operand inversion, AND/OR/full-add and result mux.
// Purely combinational.
//   a_i, b_i       operand bits
//   a_inv_i        invert a (ctrl[3])
//   b_inv_i        invert b (ctrl[2])
//   carry_i        carry into this bit
//   op_i           op field (ctrl[1:0])
//   bit_res_o      selected result bit (0 for LESS)
//   carry_next_o   carry out of this bit
//   sum_o          raw adder sum bit, used by LESS at the MSB
module serial_bit_slice
    import alu_defs::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       a_inv_i,
    input  logic       b_inv_i,
    input  logic       carry_i,
    input  logic [1:0] op_i,
    output logic       bit_res_o,
    output logic       carry_next_o,
    output logic       sum_o
);

    logic a;
    logic b;

    assign a            = a_i ^ a_inv_i;
    assign b            = b_i ^ b_inv_i;
    assign sum_o        = a ^ b ^ carry_i;
    assign carry_next_o = (a & b) | (a & carry_i) | (b & carry_i);

    always_comb begin
        bit_res_o = 1'b0;
        unique case (op_i)
            OP_AND:  bit_res_o = a & b;
            OP_OR:   bit_res_o = a | b;
            OP_ADD:  bit_res_o = sum_o;
            OP_LESS: bit_res_o = 1'b0;
            default: bit_res_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: accepts full-width operands in one handshake, then processes
// one bit per clock (LSB first) through a single slice with a registered carry.
//   clk_i       rising-edge clock
//   rst_n       asynchronous active-low reset
//   start_i     request, accepted when ready_o=1
//   ready_o     idle, can accept start_i
//   src1_i      operand A, sampled on accept
//   src2_i      operand B, sampled on accept
//   ctrl_i      operation code, sampled on accept
//   result_o    result, held until the next operation completes
//   zero_o      result_o == 0
//   cout_o      carry out of the MSB
//   overflow_o  signed overflow, ADD op field only
//   done_o      one-cycle pulse when outputs update
module serial_alu
    import alu_defs::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic             bit_res;
    logic             carry_next;
    logic             sum;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] final_res;

    // Operand registers shift right, so the current bit is always at [0].
    serial_bit_slice u_slice (
        .a_i          (a_q[0]),
        .b_i          (b_q[0]),
        .a_inv_i      (ctrl_q[3]),
        .b_inv_i      (ctrl_q[2]),
        .carry_i      (carry_q),
        .op_i         (ctrl_q[1:0]),
        .bit_res_o    (bit_res),
        .carry_next_o (carry_next),
        .sum_o        (sum)
    );

    always_comb begin
        sr_d      = {bit_res, sr_q[WIDTH-1:1]};
        final_res = sr_d;
        // SLT: set is the raw MSB sum bit, no overflow correction
        if (ctrl_q[1:0] == OP_LESS) begin
            final_res = {{(WIDTH-1){1'b0}}, sum};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            sr_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        a_q     <= src1_i;
                        b_q     <= src2_i;
                        ctrl_q  <= ctrl_i;
                        carry_q <= ctrl_i[2];
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sr_q    <= sr_d;
                    carry_q <= carry_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        // carry_q is still the carry into the MSB here
                        result_q <= final_res;
                        zero_q   <= ~|final_res;
                        cout_q   <= carry_next;
                        ovf_q    <= (ctrl_q[1:0] == OP_ADD) ? (carry_q ^ carry_next) : 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed and random operations, with
// expected results queued by the driver and checked by an independent monitor.
module tb_serial_alu;
    import alu_defs::*;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic             ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             done_o;

    serial_alu #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ctrl_i     (ctrl_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
        logic        chk_cout;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic straight from the control-field rules.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] x,
                                   input logic [31:0] y);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] s;
        a = c[3] ? ~x : x;
        b = c[2] ? ~y : y;
        s = {1'b0, a} + {1'b0, b} + {32'd0, c[2]};
        case (c[1:0])
            2'b00:   e.res = a & b;
            2'b01:   e.res = a | b;
            2'b10:   e.res = s[31:0];
            default: e.res = {31'd0, s[31]};
        endcase
        e.zero     = (e.res == 32'd0);
        e.cout     = s[32];
        e.ovf      = (c[1:0] == 2'b10) && (a[31] == b[31]) && (s[31] != a[31]);
        e.chk_cout = c[1];
        e.ctrl     = c;
        return e;
    endfunction

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result 0x%08h expected no completion", result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("result ctrl=%b", e.ctrl), result_o, e.res);
                chk($sformatf("zero ctrl=%b", e.ctrl), {31'd0, zero_o}, {31'd0, e.zero});
                chk($sformatf("overflow ctrl=%b", e.ctrl), {31'd0, overflow_o}, {31'd0, e.ovf});
                if (e.chk_cout) begin
                    chk($sformatf("cout ctrl=%b", e.ctrl), {31'd0, cout_o}, {31'd0, e.cout});
                end
            end
        end
    end

    // Issue one op; optionally pulse start_i during RUN (sampled at edge 10).
    task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input bit glitch);
        int n;
        @(negedge clk);
        chk("ready_before_start", {31'd0, ready_o}, 32'd1);
        start_i = 1'b1;
        src1_i  = x;
        src2_i  = y;
        ctrl_i  = c;
        exp_q.push_back(model(c, x, y));
        @(posedge clk);  // accept edge
        #1;
        start_i = 1'b0;
        src1_i  = $urandom;
        src2_i  = $urandom;
        ctrl_i  = 4'($urandom_range(0, 15));
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (done_o) break;
            start_i = glitch && (n == 9);
            if (start_i) begin
                src1_i = $urandom;
                src2_i = $urandom;
                ctrl_i = ALU_ADD;
            end
        end
        start_i = 1'b0;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_o after %0d cycles expected %0d", n, WIDTH);
        end else begin
            // done visible after the WIDTH-th edge following accept (cycle WIDTH+1)
            chk("latency", n, WIDTH);
            @(posedge clk);
            #1;
            chk("done_pulse_width", {31'd0, done_o}, 32'd0);
        end
    endtask

    initial begin
        start_i = 1'b0;
        src1_i  = '0;
        src2_i  = '0;
        ctrl_i  = '0;
        rst_n   = 1'b0;
        #12;
        chk("reset_ready", {31'd0, ready_o}, 32'd1);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_zero", {31'd0, zero_o}, 32'd1);
        chk("reset_cout", {31'd0, cout_o}, 32'd0);
        chk("reset_ovf", {31'd0, overflow_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(ALU_ADD, 32'h0000_0005, 32'h0000_0003, 1'b0);
        do_op(ALU_SUB, 32'h0000_0003, 32'h0000_0005, 1'b0);
        do_op(ALU_SLT, 32'h0000_0003, 32'h0000_0005, 1'b0);
        do_op(ALU_SLT, 32'h0000_0005, 32'h0000_0003, 1'b0);
        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(ALU_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0);
        do_op(ALU_NOR, 32'h0000_0000, 32'h0000_0000, 1'b0);
        do_op(ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0);
        do_op(ALU_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
        // start during RUN must be ignored; result of original op unchanged
        do_op(ALU_ADD, 32'h1234_0000, 32'h0000_5678, 1'b1);
        chk("ready_after_glitch", {31'd0, ready_o}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            do_op(4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0);
        end

        // Reset in the middle of RUN
        @(negedge clk);
        start_i = 1'b1;
        src1_i  = 32'hDEAD_BEEF;
        src2_i  = 32'h0000_0001;
        ctrl_i  = ALU_ADD;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("mid_run_not_ready", {31'd0, ready_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", {31'd0, ready_o}, 32'd1);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_result", result_o, 32'd0);
        chk("abort_zero", {31'd0, zero_o}, 32'd1);
        chk("abort_cout", {31'd0, cout_o}, 32'd0);
        chk("abort_ovf", {31'd0, overflow_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_abort", {31'd0, done_o}, 32'd0);

        do_op(ALU_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0);
        chk("final_result_held", result_o, 32'h0000_0002);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
